altr_hps_ckor_gate: RTL and testbench

- Parametrised N-input clock OR/gate with a hold-off timer.
- Any of NUM_REQ synchronous clock requests (or force_on) enables a glitch-free gated copy of clk.
- After the last request drops, the clock keeps running for HOLD_CYCLES cycles, then gates off.
- Sits at HPS clock-tree leaves feeding shared sub-blocks whose clock is needed by any of several requesters.

---
 rtl/altr_hps_ckor_gate.sv | 108 ++++++++++
 tb/tb_altr_hps_ckor_gate.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/altr_hps_ckor_gate.sv
// N-input clock OR/gate with hold-off timer: any request (or force_on) runs a
// glitch-free gated copy of clk. Optional scan override via ALTR_HPS_CKOR_GATE_SCAN_EN.
module altr_hps_ckor_gate #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef ALTR_HPS_CKOR_GATE_SCAN_EN
  input  logic               scan_en,
`endif
  input  logic [NUM_REQ-1:0] req_in,
  input  logic               force_on,
  output logic               clk_out,
  output logic               clk_active,
  output logic [NUM_REQ-1:0] wake_src,
  output logic [1:0]         state_o
);

  localparam int CW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LOAD = (HOLD_CYCLES > 0) ? CW'(HOLD_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [CW-1:0]      cnt, cnt_next;
  logic [NUM_REQ-1:0] wake_next;
  logic               any_req;
  logic               en;
  logic               en_src;
  logic               en_lat;

  assign any_req = (|req_in) | force_on;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    wake_next  = wake_src;
    case (state)
      OFF: begin
        if (any_req) begin
          state_next = RUN;
          wake_next  = req_in;
        end
      end
      RUN: begin
        if (!any_req) begin
          if (HOLD_CYCLES == 0) begin
            state_next = OFF;
          end else begin
            state_next = DRAIN;
            cnt_next   = LOAD;
          end
        end
      end
      DRAIN: begin
        if (any_req) begin
          state_next = RUN;
        end else if (cnt == '0) begin
          state_next = OFF;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      default: state_next = OFF;
    endcase
  end

  // en stays up for one cycle after the FSM returns to OFF: that is the
  // in-flight edge which makes the tail HOLD_CYCLES+1 edges long.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= OFF;
      cnt      <= '0;
      wake_src <= '0;
      en       <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      wake_src <= wake_next;
      en       <= (state_next != OFF) || (state != OFF);
    end
  end

`ifdef ALTR_HPS_CKOR_GATE_SCAN_EN
  assign en_src = en | scan_en;
`else
  assign en_src = en;
`endif

  // Latch opens only while clk is low so en_lat is frozen for the whole high phase.
  always_latch begin
    if (!rst_n) begin
      en_lat = 1'b0;
    end else if (!clk) begin
      en_lat = en_src;
    end
  end

  assign clk_out    = clk & en_lat;
  assign clk_active = en;
  assign state_o    = state;

endmodule

// File: tb/tb_altr_hps_ckor_gate.sv
// Bench for altr_hps_ckor_gate: one HOLD_CYCLES=3 instance and one HOLD_CYCLES=0 instance,
// checked against a "cycles since last request" reference model.
module tb_altr_hps_ckor_gate;
  localparam int N    = 4;
  localparam int HA   = 3;
  localparam int HB   = 0;
  localparam int HALF = 5;
  localparam int BIG  = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #HALF clk = ~clk;

  logic [N-1:0] req_a = '0, req_b = '0;
  logic         force_a = 1'b0, force_b = 1'b0;
  logic         clk_out_a, clk_out_b, clk_active_a, clk_active_b;
  logic [N-1:0] wake_src_a, wake_src_b;
  logic [1:0]   state_o_a, state_o_b;
`ifdef ALTR_HPS_CKOR_GATE_SCAN_EN
  logic         scan_en = 1'b0;
`endif

  altr_hps_ckor_gate #(.NUM_REQ(N), .HOLD_CYCLES(HA)) dut_a (
    .clk(clk), .rst_n(rst_n),
`ifdef ALTR_HPS_CKOR_GATE_SCAN_EN
    .scan_en(scan_en),
`endif
    .req_in(req_a), .force_on(force_a), .clk_out(clk_out_a),
    .clk_active(clk_active_a), .wake_src(wake_src_a), .state_o(state_o_a)
  );

  altr_hps_ckor_gate #(.NUM_REQ(N), .HOLD_CYCLES(HB)) dut_b (
    .clk(clk), .rst_n(rst_n),
`ifdef ALTR_HPS_CKOR_GATE_SCAN_EN
    .scan_en(scan_en),
`endif
    .req_in(req_b), .force_on(force_b), .clk_out(clk_out_b),
    .clk_active(clk_active_b), .wake_src(wake_src_b), .state_o(state_o_b)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: since_x = clk edges since the last edge that sampled a request.
  int           since_a = BIG, since_b = BIG;
  logic [N-1:0] wake_m_a = '0, wake_m_b = '0;
  int           exp_edges_a = 0, exp_edges_b = 0;
  int           edges_a = 0, edges_b = 0;
  int           glitches = 0;
  time          t_rise_a = 0, t_rise_b = 0;

  function automatic logic [1:0] exp_state(input int s, input int h);
    if (s == 0) return 2'd1;
    if (s <= h) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic exp_en(input int s, input int h);
    return (s <= h + 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      since_a  = BIG;
      since_b  = BIG;
      wake_m_a = '0;
      wake_m_b = '0;
    end else begin
      if (since_a <= HA + 1) exp_edges_a++;
      if (since_b <= HB + 1) exp_edges_b++;
      if (req_a != '0 || force_a) begin
        if (since_a > HA) wake_m_a = req_a;
        since_a = 0;
      end else if (since_a < BIG) since_a++;
      if (req_b != '0 || force_b) begin
        if (since_b > HB) wake_m_b = req_b;
        since_b = 0;
      end else if (since_b < BIG) since_b++;
    end
  end

  always @(posedge clk_out_a) begin edges_a++; t_rise_a = $time; end
  always @(posedge clk_out_b) begin edges_b++; t_rise_b = $time; end
  always @(negedge clk_out_a) if (rst_n && ($time - t_rise_a) != HALF) glitches++;
  always @(negedge clk_out_b) if (rst_n && ($time - t_rise_b) != HALF) glitches++;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if ({clk_out_a, clk_active_a, state_o_a, wake_src_a} !== '0) begin
      fails++; $display("FAIL reset_a: got %b want 0", {clk_out_a, clk_active_a, state_o_a, wake_src_a});
    end
    tests++;
    if ({clk_out_b, clk_active_b, state_o_b, wake_src_b} !== '0) begin
      fails++; $display("FAIL reset_b: got %b want 0", {clk_out_b, clk_active_b, state_o_b, wake_src_b});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests++;
      if ({clk_out_a, clk_active_a, state_o_a, wake_src_a, clk_active_b, state_o_b} !== '0) begin
        fails++; $display("FAIL idle_after_reset cyc %0d: got %b want 0", i,
                          {clk_out_a, clk_active_a, state_o_a, wake_src_a, clk_active_b, state_o_b});
      end
    end
    tests++;
    if (edges_a + edges_b != 0) begin
      fails++; $display("FAIL idle_edges: got %0d want 0", edges_a + edges_b);
    end
  endtask

  task automatic test_wake_hold();
    logic [N-1:0] seq [8];
    int e0;
    seq = '{4'b0100, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
    e0 = edges_a;
    for (int i = 0; i < 8; i++) begin
      req_a = seq[i];
      @(negedge clk);
      tests++;
      if (state_o_a !== exp_state(since_a, HA) || clk_active_a !== exp_en(since_a, HA)) begin
        fails++; $display("FAIL wake_hold cyc %0d: state %0d active %b want %0d %b", i,
                          state_o_a, clk_active_a, exp_state(since_a, HA), exp_en(since_a, HA));
      end
      tests++;
      if (wake_src_a !== 4'b0100) begin
        fails++; $display("FAIL wake_hold_src cyc %0d: got %b want 0100", i, wake_src_a);
      end
    end
    tests++;
    if (edges_a - e0 != 5) begin
      fails++; $display("FAIL wake_hold_edges: got %0d want 5", edges_a - e0);
    end
  endtask

  task automatic test_redrain();
    logic [N-1:0] seq [13];
    int e0;
    seq = '{4'b0001, 4'b0, 4'b0, 4'b0010, 4'b0010, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
    e0 = edges_a;
    for (int i = 0; i < 13; i++) begin
      req_a = seq[i];
      @(negedge clk);
      tests++;
      if (state_o_a !== exp_state(since_a, HA) || clk_active_a !== exp_en(since_a, HA)) begin
        fails++; $display("FAIL redrain cyc %0d: state %0d active %b want %0d %b", i,
                          state_o_a, clk_active_a, exp_state(since_a, HA), exp_en(since_a, HA));
      end
      tests++;
      if (wake_src_a !== 4'b0001) begin
        fails++; $display("FAIL redrain_src cyc %0d: got %b want 0001", i, wake_src_a);
      end
    end
    tests++;
    if (edges_a - e0 != 9) begin
      fails++; $display("FAIL redrain_edges: got %0d want 9", edges_a - e0);
    end
  endtask

  task automatic test_edge_race();
    logic [N-1:0] seq [11];
    int e0;
    seq = '{4'b0100, 4'b0, 4'b0, 4'b0, 4'b1000, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
    e0 = edges_a;
    for (int i = 0; i < 11; i++) begin
      req_a = seq[i];
      @(negedge clk);
      tests++;
      if (state_o_a !== exp_state(since_a, HA) || clk_active_a !== exp_en(since_a, HA)) begin
        fails++; $display("FAIL edge_race cyc %0d: state %0d active %b want %0d %b", i,
                          state_o_a, clk_active_a, exp_state(since_a, HA), exp_en(since_a, HA));
      end
      if (i == 3 || i == 4) begin
        tests++;
        if (state_o_a !== ((i == 3) ? 2'd2 : 2'd1)) begin
          fails++; $display("FAIL edge_race_state cyc %0d: got %0d want %0d", i, state_o_a, (i == 3) ? 2 : 1);
        end
      end
      tests++;
      if (wake_src_a !== 4'b0100) begin
        fails++; $display("FAIL edge_race_src cyc %0d: got %b want 0100", i, wake_src_a);
      end
    end
    tests++;
    if (edges_a - e0 != 9) begin
      fails++; $display("FAIL edge_race_edges: got %0d want 9", edges_a - e0);
    end
  endtask

  task automatic test_hold0();
    logic [N-1:0] seq [6];
    logic [1:0]   want [6];
    int e0;
    seq  = '{4'b0001, 4'b0001, 4'b0001, 4'b0, 4'b0, 4'b0};
    want = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
    e0 = edges_b;
    for (int i = 0; i < 6; i++) begin
      req_b = seq[i];
      @(negedge clk);
      tests++;
      if (state_o_b !== want[i] || clk_active_b !== exp_en(since_b, HB)) begin
        fails++; $display("FAIL hold0 cyc %0d: state %0d active %b want %0d %b", i,
                          state_o_b, clk_active_b, want[i], exp_en(since_b, HB));
      end
    end
    tests++;
    if (edges_b - e0 != 4) begin
      fails++; $display("FAIL hold0_edges: got %0d want 4", edges_b - e0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      req_a   = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
      req_b   = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
      force_a = ($urandom_range(0, 15) == 0);
      force_b = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      tests++;
      if (state_o_a !== exp_state(since_a, HA) || clk_active_a !== exp_en(since_a, HA) ||
          wake_src_a !== wake_m_a) begin
        fails++; $display("FAIL random_a cyc %0d: st %0d act %b wake %b want %0d %b %b", i, state_o_a,
                          clk_active_a, wake_src_a, exp_state(since_a, HA), exp_en(since_a, HA), wake_m_a);
      end
      tests++;
      if (state_o_b !== exp_state(since_b, HB) || clk_active_b !== exp_en(since_b, HB) ||
          wake_src_b !== wake_m_b) begin
        fails++; $display("FAIL random_b cyc %0d: st %0d act %b wake %b want %0d %b %b", i, state_o_b,
                          clk_active_b, wake_src_b, exp_state(since_b, HB), exp_en(since_b, HB), wake_m_b);
      end
    end
    req_a = '0; req_b = '0; force_a = 1'b0; force_b = 1'b0;
    repeat (10) @(negedge clk);
    tests++;
    if (edges_a !== exp_edges_a || edges_b !== exp_edges_b) begin
      fails++; $display("FAIL random_edges: got %0d/%0d want %0d/%0d", edges_a, edges_b, exp_edges_a, exp_edges_b);
    end
    tests++;
    if (glitches != 0) begin
      fails++; $display("FAIL pulse_width: got %0d short pulses want 0", glitches);
    end
  endtask

  task automatic test_async_reset();
    req_a = 4'b1111; req_b = 4'b0001;
    @(negedge clk);
    @(posedge clk);
    #1;
    tests++;
    if (clk_out_a !== 1'b1 || clk_out_b !== 1'b1) begin
      fails++; $display("FAIL run_high: got %b%b want 11", clk_out_a, clk_out_b);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({clk_out_a, clk_out_b, clk_active_a, clk_active_b, state_o_a, state_o_b} !== '0) begin
      fails++; $display("FAIL async_reset: got %b want 0",
                        {clk_out_a, clk_out_b, clk_active_a, clk_active_b, state_o_a, state_o_b});
    end
    @(negedge clk);
    req_a = '0; req_b = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
`ifdef ALTR_HPS_CKOR_GATE_SCAN_EN
    scan_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      tests++;
      if (clk_out_a !== 1'b1 || clk_active_a !== 1'b0 || state_o_a !== 2'd0) begin
        fails++; $display("FAIL scan_high cyc %0d: out %b act %b st %0d want 1 0 0", i,
                          clk_out_a, clk_active_a, state_o_a);
      end
      @(negedge clk);
      #1;
      tests++;
      if (clk_out_a !== 1'b0) begin
        fails++; $display("FAIL scan_low cyc %0d: got %b want 0", i, clk_out_a);
      end
    end
    @(negedge clk);
    scan_en = 1'b0;
    repeat (3) @(negedge clk);
    exp_edges_a = edges_a;
    exp_edges_b = edges_b;
`endif
    tests++;
    if (edges_a !== exp_edges_a || edges_b !== exp_edges_b || glitches != 0) begin
      fails++; $display("FAIL final_edges: got %0d/%0d g%0d want %0d/%0d g0",
                        edges_a, edges_b, glitches, exp_edges_a, exp_edges_b);
    end
  endtask

  initial begin
    test_reset();
    test_wake_hold();
    test_redrain();
    test_edge_race();
    test_hold0();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
